dsp_int8_dual_accum: RTL and testbench

Downstream consumer of the packed int8 DSP multiplier. Each beat carries one packed word holding two signed int8×int8 products that share one multiplicand: hi = a·c, lo = b·c, with p = hi·2^SHIFT + lo. The block unpacks both products, applies the borrow correction, and accumulates them into two independent saturating dot-product accumulators. On the last term of a vector it emits a result beat over a valid/ready handshake.

---
 rtl/dsp_int8_dual_accum.sv | 119 +++++++++++
 tb/tb_dsp_int8_dual_accum.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_int8_dual_accum.sv
// dsp_int8_dual_accum: unpacks two int8 products from one packed word
// and accumulates each into its own saturating dot-product accumulator.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     term handshake
//   in_p                  packed word, hi*2^SHIFT + lo (signed)
//   in_last               term closes the current vector
//   out_valid/out_ready   result handshake
//   out_acc_hi/lo         saturated sums of hi and lo products
//   out_len               terms in the result (saturating)
//   out_ovf               either accumulator saturated in this vector
module dsp_int8_dual_accum #(
  parameter int SHIFT  = 18,
  parameter int P_W    = 36,
  parameter int PROD_W = 16,
  parameter int ACC_W  = 32,
  parameter int LEN_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [P_W-1:0]   in_p,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_acc_hi,
  output logic signed [ACC_W-1:0] out_acc_lo,
  output logic [LEN_W-1:0]        out_len,
  output logic                    out_ovf
);

  localparam int SUM_W = ACC_W + 1;

  logic signed [ACC_W-1:0] acc_hi;
  logic signed [ACC_W-1:0] acc_lo;
  logic [LEN_W-1:0]        len;
  logic                    ovf;

  logic signed [P_W-1:0]   borrow;
  logic signed [P_W-1:0]   hi_p;
  logic signed [SUM_W-1:0] hi_t;
  logic signed [SUM_W-1:0] lo_t;
  logic signed [SUM_W-1:0] sum_hi;
  logic signed [SUM_W-1:0] sum_lo;
  logic signed [ACC_W-1:0] nxt_hi;
  logic signed [ACC_W-1:0] nxt_lo;
  logic                    sat_hi;
  logic                    sat_lo;
  logic [LEN_W-1:0]        nxt_len;
  logic                    take;

  function automatic logic signed [ACC_W-1:0] clamp(
    input logic signed [SUM_W-1:0] x
  );
    if (x[SUM_W-1] != x[SUM_W-2])
      clamp = x[SUM_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                         : {1'b0, {(ACC_W-1){1'b1}}};
    else
      clamp = x[ACC_W-1:0];
  endfunction

  // A negative lo field borrows one from the hi field when the two
  // products are summed into one word; adding lo's sign bit undoes it.
  assign borrow = {{(P_W-1){1'b0}}, in_p[PROD_W-1]};
  assign hi_p   = (in_p >>> SHIFT) + borrow;
  assign hi_t   = SUM_W'(hi_p);
  assign lo_t   = SUM_W'($signed(in_p[PROD_W-1:0]));

  assign sum_hi = SUM_W'(acc_hi) + hi_t;
  assign sum_lo = SUM_W'(acc_lo) + lo_t;
  assign sat_hi = sum_hi[SUM_W-1] != sum_hi[SUM_W-2];
  assign sat_lo = sum_lo[SUM_W-1] != sum_lo[SUM_W-2];
  assign nxt_hi = clamp(sum_hi);
  assign nxt_lo = clamp(sum_lo);

  assign nxt_len = (&len) ? len : len + LEN_W'(1);

  assign in_ready = ~out_valid | out_ready;
  assign take     = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hi     <= '0;
      acc_lo     <= '0;
      len        <= '0;
      ovf        <= 1'b0;
      out_valid  <= 1'b0;
      out_acc_hi <= '0;
      out_acc_lo <= '0;
      out_len    <= '0;
      out_ovf    <= 1'b0;
    end else begin
      if (out_valid & out_ready)
        out_valid <= 1'b0;
      if (take) begin
        if (in_last) begin
          // a new result may load on the same edge the old one drains
          out_valid  <= 1'b1;
          out_acc_hi <= nxt_hi;
          out_acc_lo <= nxt_lo;
          out_len    <= nxt_len;
          out_ovf    <= ovf | sat_hi | sat_lo;
          acc_hi     <= '0;
          acc_lo     <= '0;
          len        <= '0;
          ovf        <= 1'b0;
        end else begin
          acc_hi <= nxt_hi;
          acc_lo <= nxt_lo;
          len    <= nxt_len;
          ovf    <= ovf | sat_hi | sat_lo;
        end
      end
    end
  end

endmodule

// File: tb/tb_dsp_int8_dual_accum.sv
// tb_dsp_int8_dual_accum: directed and random checks of the dual
// saturating accumulator (32-bit instance plus a 16-bit instance).
module tb_dsp_int8_dual_accum;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic in_last;
  logic out_ready;
  logic signed [35:0] in_p;

  logic in_ready, out_valid, out_ovf;
  logic signed [31:0] out_acc_hi, out_acc_lo;
  logic [15:0] out_len;

  logic s_in_ready, s_out_valid, s_ovf;
  logic signed [15:0] s_hi, s_lo;
  logic [15:0] s_len;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dsp_int8_dual_accum dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_p(in_p), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc_hi(out_acc_hi), .out_acc_lo(out_acc_lo),
    .out_len(out_len), .out_ovf(out_ovf)
  );

  dsp_int8_dual_accum #(.ACC_W(16)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_p(in_p), .in_last(in_last),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_acc_hi(s_hi), .out_acc_lo(s_lo),
    .out_len(s_len), .out_ovf(s_ovf)
  );

  function automatic logic signed [35:0] pack(input int hi, input int lo);
    longint v;
    v = longint'(hi) * 262144 + longint'(lo);
    return v[35:0];
  endfunction

  // present one term at a negedge and hold it until accepted
  task automatic put(input int hi, input int lo, input logic last);
    int n;
    in_valid = 1'b1;
    in_p = pack(hi, lo);
    in_last = last;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!in_ready) begin
      bad++;
      $display("FAIL put_timeout in_ready=%b want 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_p = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got %b want 1", in_ready); end
    total++; if (out_acc_hi !== 0) begin bad++; $display("FAIL rst_hi got %0d want 0", out_acc_hi); end
    total++; if (out_acc_lo !== 0) begin bad++; $display("FAIL rst_lo got %0d want 0", out_acc_lo); end
    total++; if (out_len !== 0) begin bad++; $display("FAIL rst_len got %0d want 0", out_len); end
    total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf got %b want 0", out_ovf); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_borrow();
    out_ready = 1'b1;
    @(negedge clk);
    put(-30, -15, 1'b1);
    idle();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL brw_valid got %b want 1", out_valid); end
    total++; if (out_acc_hi !== -30) begin bad++; $display("FAIL brw_hi got %0d want -30", out_acc_hi); end
    total++; if (out_acc_lo !== -15) begin bad++; $display("FAIL brw_lo got %0d want -15", out_acc_lo); end
    total++; if (out_len !== 1) begin bad++; $display("FAIL brw_len got %0d want 1", out_len); end
    total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL brw_ovf got %b want 0", out_ovf); end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL brw_drain got %b want 0", out_valid); end
  endtask

  task automatic test_vector();
    out_ready = 1'b1;
    @(negedge clk);
    put(-30, -15, 1'b0);
    put(-24, 8, 1'b0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL vec_early got %b want 0", out_valid); end
    put(-1, -1, 1'b1);
    idle();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL vec_valid got %b want 1", out_valid); end
    total++; if (out_acc_hi !== -55) begin bad++; $display("FAIL vec_hi got %0d want -55", out_acc_hi); end
    total++; if (out_acc_lo !== -8) begin bad++; $display("FAIL vec_lo got %0d want -8", out_acc_lo); end
    total++; if (out_len !== 3) begin bad++; $display("FAIL vec_len got %0d want 3", out_len); end
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    @(negedge clk);
    put(16384, -16384, 1'b0);
    put(16384, -16384, 1'b0);
    put(16384, -16384, 1'b1);
    idle();
    total++; if (s_hi !== 32767) begin bad++; $display("FAIL sat_hi got %0d want 32767", s_hi); end
    total++; if (s_lo !== -32768) begin bad++; $display("FAIL sat_lo got %0d want -32768", s_lo); end
    total++; if (s_ovf !== 1'b1) begin bad++; $display("FAIL sat_ovf got %b want 1", s_ovf); end
    total++; if (s_len !== 3) begin bad++; $display("FAIL sat_len got %0d want 3", s_len); end
    total++; if (out_acc_hi !== 49152) begin bad++; $display("FAIL wide_hi got %0d want 49152", out_acc_hi); end
    total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL wide_ovf got %b want 0", out_ovf); end
    put(1, 1, 1'b1);
    idle();
    total++; if (s_hi !== 1) begin bad++; $display("FAIL sat2_hi got %0d want 1", s_hi); end
    total++; if (s_lo !== 1) begin bad++; $display("FAIL sat2_lo got %0d want 1", s_lo); end
    total++; if (s_ovf !== 1'b0) begin bad++; $display("FAIL sat2_ovf got %b want 0", s_ovf); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    put(5, 6, 1'b1);
    in_p = pack(9, 10);
    in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d] got %b want 0", i, in_ready); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got %b want 1", i, out_valid); end
      total++; if (out_acc_hi !== 5 || out_acc_lo !== 6 || out_len !== 1)
        begin bad++; $display("FAIL bp_hold[%0d] got %0d/%0d/%0d want 5/6/1", i, out_acc_hi, out_acc_lo, out_len); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    idle();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_nobub got %b want 1", out_valid); end
    total++; if (out_acc_hi !== 9 || out_acc_lo !== 10 || out_len !== 1)
      begin bad++; $display("FAIL bp_new got %0d/%0d/%0d want 9/10/1", out_acc_hi, out_acc_lo, out_len); end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1;
      in_p = pack(i, -i);
      in_last = 1'b1;
      @(negedge clk);
      total++; if (out_valid !== 1'b1 || out_acc_hi !== i || out_acc_lo !== -i || out_len !== 1)
        begin bad++; $display("FAIL b2b[%0d] got v=%b %0d/%0d/%0d want 1 %0d/%0d/1", i, out_valid, out_acc_hi, out_acc_lo, out_len, i, -i); end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    @(negedge clk);
    put(100, 100, 1'b0);
    put(100, 100, 1'b0);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (out_acc_hi !== 0 || out_len !== 0) begin bad++; $display("FAIL arst_out got %0d/%0d want 0/0", out_acc_hi, out_len); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL arst_ready got %b want 1", in_ready); end
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    put(7, -3, 1'b1);
    idle();
    total++; if (out_acc_hi !== 7) begin bad++; $display("FAIL mid_hi got %0d want 7", out_acc_hi); end
    total++; if (out_acc_lo !== -3) begin bad++; $display("FAIL mid_lo got %0d want -3", out_acc_lo); end
    total++; if (out_len !== 1) begin bad++; $display("FAIL mid_len got %0d want 1", out_len); end
    total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL mid_ovf got %b want 0", out_ovf); end
  endtask

  task automatic test_random();
    int qh[$], ql[$], qn[$];
    int nv, got, iter;
    nv = 20;
    got = 0;
    iter = 0;
    @(negedge clk);
    fork
      begin
        for (int v = 0; v < nv; v++) begin
          int n, eh, el;
          n = $urandom_range(64, 1);
          eh = 0;
          el = 0;
          for (int t = 0; t < n; t++) begin
            int a, b, c;
            a = int'($urandom_range(255, 0)) - 128;
            b = int'($urandom_range(255, 0)) - 128;
            c = int'($urandom_range(255, 0)) - 128;
            eh += a * c;
            el += b * c;
            if (t == n - 1) begin
              qh.push_back(eh);
              ql.push_back(el);
              qn.push_back(n);
            end
            put(a * c, b * c, t == n - 1);
          end
        end
        idle();
      end
      begin
        while (got < nv && iter < 20000) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(1, 0));
          if (out_valid && out_ready && qh.size() > 0) begin
            total++;
            if (out_acc_hi !== qh[0] || out_acc_lo !== ql[0] || out_len !== qn[0] || out_ovf !== 1'b0)
              begin bad++; $display("FAIL rnd[%0d] got %0d/%0d/%0d/%b want %0d/%0d/%0d/0", got, out_acc_hi, out_acc_lo, out_len, out_ovf, qh[0], ql[0], qn[0]); end
            void'(qh.pop_front());
            void'(ql.pop_front());
            void'(qn.pop_front());
            got++;
          end
          iter++;
        end
      end
    join
    total++;
    if (got != nv) begin bad++; $display("FAIL rnd_count got %0d want %0d", got, nv); end
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_borrow();
    test_vector();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
